countdown_nm: RTL and testbench

Loadable two-digit down-counter (timer) that runs the N:M chained counting scheme in reverse: the low digit counts modulo M from a preset toward zero and borrows from the high digit, which counts modulo N. Terminal count 0:0 produces a one-cycle `done` pulse. It sits beside the up-counters in the circuit-test project. It provides the countdown/timeout function that the up-counters cannot, driven by the same `enable` tick.

---
 rtl/countdown_pkg.sv | 16 +
 rtl/down_digit.sv | 40 ++++
 rtl/countdown_nm.sv | 164 ++++++++++++++++
 tb/tb_countdown_nm.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and default geometry for the N:M countdown timer.
package countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int unsigned DEF_M_MOD = 13;
   localparam int unsigned DEF_N_MOD = 10;
   localparam int unsigned DEF_M_W   = 4;
   localparam int unsigned DEF_N_W   = 4;

endpackage

// File: rtl/down_digit.sv
// Generic modulo-K down-counting digit; wraps 0 -> K-1 and flags the borrow.
module down_digit #(
   parameter int unsigned K = 10,
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec_in,
   output logic [W-1:0] count,
   output logic         zero,
   output logic         borrow_out
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign zero       = (count_q == '0);
   assign borrow_out = dec_in && zero;
   assign count      = count_q;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec_in) begin
         count_d = zero ? W'(K - 1) : count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/countdown_nm.sv
// Loadable two-digit N:M countdown timer with one-cycle done/borrow pulses.
// Build with COUNTDOWN_NM_AUTO_RELOAD_EN for a periodic (auto-reloading) timer.
module countdown_nm
   import countdown_pkg::*;
#(
   parameter int unsigned M_MOD = DEF_M_MOD,
   parameter int unsigned N_MOD = DEF_N_MOD,
   parameter int unsigned M_W   = DEF_M_W,
   parameter int unsigned N_W   = DEF_N_W
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic           load,
   input  logic [N_W-1:0] load_N,
   input  logic [M_W-1:0] load_M,
   input  logic           start,
   input  logic           pause,
   output logic [N_W-1:0] count_N,
   output logic [M_W-1:0] count_M,
   output logic           borrow_out_M,
   output logic           done,
   output logic           busy
);

   state_e         state_q, state_d;
   logic [N_W-1:0] preset_n_q;
   logic [M_W-1:0] preset_m_q;
   logic           done_q, done_d;
   logic           borrow_q, borrow_d;
   logic           busy_q, busy_d;

   logic           dig_load_c, use_preset_c, dec_c;
   logic [N_W-1:0] ld_n_c, dig_n_val_c;
   logic [M_W-1:0] ld_m_c, dig_m_val_c;
   logic           m_zero, n_zero, m_borrow, n_borrow_unused;
   logic           cnt_zero_c, preset_zero_c, term_c;

   // Out-of-range presets saturate at modulus-1.
   assign ld_n_c = (32'(load_N) >= N_MOD) ? N_W'(N_MOD - 1) : load_N;
   assign ld_m_c = (32'(load_M) >= M_MOD) ? M_W'(M_MOD - 1) : load_M;

   assign dig_n_val_c   = use_preset_c ? preset_n_q : ld_n_c;
   assign dig_m_val_c   = use_preset_c ? preset_m_q : ld_m_c;
   assign cnt_zero_c    = n_zero && m_zero;
   assign preset_zero_c = (preset_n_q == '0) && (preset_m_q == '0);
   assign term_c        = n_zero && (count_M == M_W'(1));

   down_digit #(.K(M_MOD), .W(M_W)) u_digit_m (
      .clk        (clk),
      .reset      (reset),
      .load       (dig_load_c),
      .load_val   (dig_m_val_c),
      .dec_in     (dec_c),
      .count      (count_M),
      .zero       (m_zero),
      .borrow_out (m_borrow)
   );

   down_digit #(.K(N_MOD), .W(N_W)) u_digit_n (
      .clk        (clk),
      .reset      (reset),
      .load       (dig_load_c),
      .load_val   (dig_n_val_c),
      .dec_in     (m_borrow),
      .count      (count_N),
      .zero       (n_zero),
      .borrow_out (n_borrow_unused)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: if (start) state_d = cnt_zero_c ? ST_DONE : ST_RUN;
            ST_DONE: if (start) state_d = preset_zero_c ? ST_DONE : ST_RUN;
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_HOLD;
               end else if (enable && term_c) begin
`ifdef COUNTDOWN_NM_AUTO_RELOAD_EN
                  state_d = preset_zero_c ? ST_DONE : ST_RUN;
`else
                  state_d = ST_DONE;
`endif
               end
            end
            ST_HOLD: if (!pause) state_d = ST_RUN;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Digit controls and next values of the registered pulse/status outputs.
   always_comb begin
      dig_load_c   = 1'b0;
      use_preset_c = 1'b0;
      dec_c        = 1'b0;
      done_d       = 1'b0;
      borrow_d     = 1'b0;
      busy_d       = (state_d == ST_RUN) || (state_d == ST_HOLD);
      if (load) begin
         dig_load_c = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: done_d = start && cnt_zero_c;
            ST_DONE: begin
               if (start) begin
                  dig_load_c   = 1'b1;
                  use_preset_c = 1'b1;
                  done_d       = preset_zero_c;
               end
            end
            ST_RUN: begin
               if (!pause && enable && !cnt_zero_c) begin
                  dec_c    = 1'b1;
                  borrow_d = m_zero;
                  done_d   = term_c;
`ifdef COUNTDOWN_NM_AUTO_RELOAD_EN
                  if (term_c && !preset_zero_c) begin
                     dig_load_c   = 1'b1;
                     use_preset_c = 1'b1;
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         preset_n_q <= '0;
         preset_m_q <= '0;
         done_q     <= 1'b0;
         borrow_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         if (load) begin
            preset_n_q <= ld_n_c;
            preset_m_q <= ld_m_c;
         end
         done_q   <= done_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
      end
   end

   assign done         = done_q;
   assign borrow_out_M = borrow_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_countdown_nm.sv
// Scoreboard bench for countdown_nm: stimulus queues expected snapshots, a monitor checks them.
module tb_countdown_nm;

   logic       clk = 1'b0;
   logic       reset = 1'b0, enable = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
   logic [3:0] load_N = '0, load_M = '0;
   logic [3:0] count_N, count_M;
   logic       borrow_out_M, done, busy;

   typedef struct {
      logic [3:0] n;
      logic [3:0] m;
      logic       d;
      logic       b;
      logic       bz;
      string      nm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [4:0] RS = 5'b10000;
   localparam logic [4:0] LD = 5'b01000;
   localparam logic [4:0] ST = 5'b00100;
   localparam logic [4:0] PS = 5'b00010;
   localparam logic [4:0] EN = 5'b00001;

   countdown_nm dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .load         (load),
      .load_N       (load_N),
      .load_M       (load_M),
      .start        (start),
      .pause        (pause),
      .count_N      (count_N),
      .count_M      (count_M),
      .borrow_out_M (borrow_out_M),
      .done         (done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Apply one cycle of controls and queue the state expected after that edge.
   task automatic cyc(input logic [4:0] c, input int en, input int em, input int ed,
                      input int eb, input int ebz, input string nm);
      exp_t e;
      {reset, load, start, pause, enable} = c;
      @(posedge clk);
      #1;
      e.n  = 4'(en);
      e.m  = 4'(em);
      e.d  = 1'(ed);
      e.b  = 1'(eb);
      e.bz = 1'(ebz);
      e.nm = nm;
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({count_N, count_M, done, borrow_out_M, busy} !== {e.n, e.m, e.d, e.b, e.bz}) begin
               errors++;
               $display("FAIL %s: got %0d:%0d done=%b borrow=%b busy=%b, want %0d:%0d done=%b borrow=%b busy=%b",
                        e.nm, count_N, count_M, done, borrow_out_M, busy,
                        e.n, e.m, e.d, e.b, e.bz);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int rem;
      #2;
      cyc(RS, 0, 0, 0, 0, 0, "reset_init");

      // Reset mid-countdown at 3:7 clears counts and presets.
      load_N = 4'd3; load_M = 4'd7;
      cyc(LD, 3, 7, 0, 0, 0, "load37");
      cyc(ST, 3, 7, 0, 0, 1, "start37");
      cyc(RS | EN, 0, 0, 0, 0, 0, "reset_in_run");
      cyc(ST, 0, 0, 1, 0, 0, "start_zero_after_reset");
      cyc(ST, 0, 0, 1, 0, 0, "preset_cleared");
      cyc(5'b0, 0, 0, 0, 0, 0, "done_single_pulse");

`ifdef COUNTDOWN_NM_AUTO_RELOAD_EN
      load_N = 4'd0; load_M = 4'd2;
      cyc(LD, 0, 2, 0, 0, 0, "load02");
      cyc(ST | EN, 0, 2, 0, 0, 1, "start02");
      for (int k = 1; k <= 6; k++) begin
         if (k % 2 == 1) cyc(EN, 0, 1, 0, 0, 1, "auto_dec");
         else            cyc(EN, 0, 2, 1, 0, 1, "auto_reload");
      end
      cyc(PS | EN, 0, 2, 0, 0, 1, "auto_pause");
      cyc(5'b0, 0, 2, 0, 0, 1, "auto_resume");
      load_N = 4'd0; load_M = 4'd0;
      cyc(LD, 0, 0, 0, 0, 0, "auto_load00");
      cyc(ST, 0, 0, 1, 0, 0, "auto_zero_start");
      cyc(EN, 0, 0, 0, 0, 0, "auto_zero_stays_done");
`else
      // Full countdown from 1:2 (15 ticks); start and enable together only start.
      load_N = 4'd1; load_M = 4'd2;
      cyc(LD, 1, 2, 0, 0, 0, "load12");
      cyc(LD | ST, 1, 2, 0, 0, 0, "load_beats_start");
      cyc(ST | EN, 1, 2, 0, 0, 1, "start12_no_dec");
      for (int k = 1; k <= 15; k++) begin
         rem = 15 - k;
         cyc(EN, rem / 13, rem % 13, (k == 15) ? 1 : 0, (k == 3) ? 1 : 0,
             (k < 15) ? 1 : 0, "countdown");
      end
      cyc(EN, 0, 0, 0, 0, 0, "done_hold");
      cyc(EN | PS, 0, 0, 0, 0, 0, "done_ignores_pause");

      // Restart from DONE reloads the preset, then abort with load at 0:3.
      cyc(ST, 1, 2, 0, 0, 1, "restart_reload");
      for (int k = 1; k <= 12; k++) begin
         rem = 15 - k;
         cyc(EN, rem / 13, rem % 13, 0, (k == 3) ? 1 : 0, 1, "recount");
      end
      load_N = 4'd2; load_M = 4'd5;
      cyc(LD | EN, 2, 5, 0, 0, 0, "abort_load");
      cyc(EN, 2, 5, 0, 0, 0, "abort_idle");
      cyc(EN, 2, 5, 0, 0, 0, "abort_no_done");

      // Pause holds 0:5 for four cycles, then five ticks finish.
      load_N = 4'd0; load_M = 4'd5;
      cyc(LD, 0, 5, 0, 0, 0, "load05");
      cyc(ST, 0, 5, 0, 0, 1, "start05");
      for (int k = 0; k < 4; k++) cyc(PS | EN, 0, 5, 0, 0, 1, "paused");
      cyc(ST, 0, 5, 0, 0, 1, "resume_start_ignored");
      for (int k = 1; k <= 5; k++)
         cyc(EN, 0, 5 - k, (k == 5) ? 1 : 0, 0, (k < 5) ? 1 : 0, "after_pause");

      // Clamp out-of-range presets, then zero preset starts straight to done.
      load_N = 4'd12; load_M = 4'd15;
      cyc(LD, 9, 12, 0, 0, 0, "clamp");
      cyc(ST, 9, 12, 0, 0, 1, "start_clamped");
      cyc(EN, 9, 11, 0, 0, 1, "clamped_dec");
      load_N = 4'd0; load_M = 4'd0;
      cyc(LD, 0, 0, 0, 0, 0, "load00");
      cyc(ST, 0, 0, 1, 0, 0, "zero_start_done");
      cyc(EN, 0, 0, 0, 0, 0, "zero_start_after");
`endif

      cyc(5'b0, 0, 0, 0, 0, 0, "final_idle");
      repeat (3) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left unchecked, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
